// File: rtl/w0rm_mem_port_arbiter.sv
// Memory bus arbiter shared by instruction fetch and load/store.
// Data side has priority; a starvation counter forces fetch progress.
module w0rm_mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INST_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_req_addr,
  input  logic                  if_flush,
  output logic                  if_req_ready,
  output logic                  if_resp_valid,
  output logic [INST_WIDTH-1:0] if_resp_data,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic                  d_req_write,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [DATA_WIDTH-1:0] d_resp_data,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CW-1:0]   starve_r;
  logic            grant_d_s;
  logic            grant_i_s;
  logic            fetch_ok_s;
  logic            starve_hit_s;
  logic            owner_i_r;
  logic            lane_r;
  logic            drop_r;
  logic            unused_addr_bit_s;

  logic                  if_resp_valid_r;
  logic [INST_WIDTH-1:0] if_resp_data_r;
  logic                  d_resp_valid_r;
  logic [DATA_WIDTH-1:0] d_resp_data_r;
  logic                  mem_valid_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  mem_write_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;

  assign unused_addr_bit_s = if_req_addr[0];
  assign fetch_ok_s        = if_req_valid && !if_flush;
  assign starve_hit_s      = (starve_r == CW'(STARVE_LIMIT));

  // Grant decision and next-state logic
  always_comb begin
    grant_d_s    = 1'b0;
    grant_i_s    = 1'b0;
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (reset) begin
          state_next_s = ST_IDLE;
        end else if (d_req_valid && !(fetch_ok_s && starve_hit_s)) begin
          grant_d_s    = 1'b1;
          state_next_s = ST_ISSUE;
        end else if (fetch_ok_s) begin
          grant_i_s    = 1'b1;
          state_next_s = ST_ISSUE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) state_next_s = ST_WAIT;
        else           state_next_s = ST_ISSUE;
      end
      ST_WAIT: begin
        if (mem_resp_valid) state_next_s = ST_IDLE;
        else                state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign d_req_ready  = grant_d_s;
  assign if_req_ready = grant_i_s;

  // Consecutive data grants seen by a waiting fetch
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_r <= {CW{1'b0}};
    end else if (grant_i_s || !if_req_valid) begin
      starve_r <= {CW{1'b0}};
    end else if (grant_d_s && !starve_hit_s) begin
      starve_r <= starve_r + CW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

  // Bus command, ownership and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      owner_i_r       <= 1'b0;
      lane_r          <= 1'b0;
      drop_r          <= 1'b0;
      mem_valid_r     <= 1'b0;
      mem_addr_r      <= {ADDR_WIDTH{1'b0}};
      mem_write_r     <= 1'b0;
      mem_wdata_r     <= {DATA_WIDTH{1'b0}};
      if_resp_valid_r <= 1'b0;
      if_resp_data_r  <= {INST_WIDTH{1'b0}};
      d_resp_valid_r  <= 1'b0;
      d_resp_data_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r         <= state_next_s;
      if_resp_valid_r <= 1'b0;
      d_resp_valid_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          drop_r <= 1'b0;
          if (grant_d_s) begin
            mem_valid_r <= 1'b1;
            mem_addr_r  <= d_req_addr;
            mem_write_r <= d_req_write;
            mem_wdata_r <= d_req_wdata;
            owner_i_r   <= 1'b0;
          end else if (grant_i_s) begin
            mem_valid_r <= 1'b1;
            mem_addr_r  <= {if_req_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_write_r <= 1'b0;
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            owner_i_r   <= 1'b1;
            lane_r      <= if_req_addr[1];
          end
        end
        ST_ISSUE: begin
          if (mem_ready) mem_valid_r <= 1'b0;
          if (owner_i_r && if_flush) drop_r <= 1'b1;
        end
        ST_WAIT: begin
          if (owner_i_r && if_flush) drop_r <= 1'b1;
          if (mem_resp_valid) begin
            drop_r <= 1'b0;
            if (owner_i_r) begin
              // a flush in the response cycle drops it as well
              if_resp_valid_r <= !(drop_r || if_flush);
              if_resp_data_r  <= lane_r ? mem_resp_data[2*INST_WIDTH-1:INST_WIDTH]
                                        : mem_resp_data[INST_WIDTH-1:0];
            end else begin
              d_resp_valid_r <= 1'b1;
              d_resp_data_r  <= mem_write_r ? {DATA_WIDTH{1'b0}} : mem_resp_data;
            end
          end
        end
        default: mem_valid_r <= 1'b0;
      endcase
    end
  end

  assign if_resp_valid = if_resp_valid_r;
  assign if_resp_data  = if_resp_data_r;
  assign d_resp_valid  = d_resp_valid_r;
  assign d_resp_data   = d_resp_data_r;
  assign mem_valid     = mem_valid_r;
  assign mem_addr      = mem_addr_r;
  assign mem_write     = mem_write_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_w0rm_mem_port_arbiter.sv
// Scoreboard bench for w0rm_mem_port_arbiter with a simple bus responder.
module tb_w0rm_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_valid, if_flush, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr;
  logic [15:0] if_resp_data;
  logic        d_req_valid, d_req_write, d_req_ready, d_resp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_resp_data;
  logic        mem_valid, mem_write, mem_ready, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_resp_data;

  always #5 clk = ~clk;

  w0rm_mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_flush(if_flush),
    .if_req_ready(if_req_ready), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_addr(d_req_addr), .d_req_write(d_req_write),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid),
    .d_resp_data(d_resp_data), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_write(mem_write), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  typedef struct { logic [31:0] data; int acc; } resp_t;
  typedef struct { logic [31:0] addr; logic wr; logic [31:0] wdata; } cmd_t;

  resp_t       exp_d[$];
  resp_t       exp_i[$];
  cmd_t        exp_cmd[$];
  logic        grant_log[$];   // 1 = fetch, 0 = data
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_d_lat = 0;
  int          stall = 0;
  logic        bus_hold = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: scoreboard bus commands and responses, then drive the bus model.
  task automatic tick();
    logic  hs;
    cmd_t  c;
    resp_t e;
    hs = mem_valid && mem_ready;
    if (hs) begin
      check_eq("cmd_expected", 32'(exp_cmd.size() > 0), 32'd1);
      if (exp_cmd.size() > 0) begin
        c = exp_cmd.pop_front();
        check_eq("mem_addr", mem_addr, c.addr);
        check_eq("mem_write", 32'(mem_write), 32'(c.wr));
        check_eq("mem_wdata", mem_wdata, c.wdata);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (d_resp_valid) begin
      check_eq("d_expected", 32'(exp_d.size() > 0), 32'd1);
      if (exp_d.size() > 0) begin
        e = exp_d.pop_front();
        check_eq("d_resp_data", d_resp_data, e.data);
        last_d_lat = cyc - e.acc;
      end
    end
    if (if_resp_valid) begin
      check_eq("i_expected", 32'(exp_i.size() > 0), 32'd1);
      if (exp_i.size() > 0) begin
        e = exp_i.pop_front();
        check_eq("if_resp_data", {16'h0, if_resp_data}, e.data);
      end
    end
    mem_resp_valid = hs && !bus_hold && !reset;
    mem_resp_data  = hs ? bus_rdata : 32'h0;
    if (mem_valid && stall > 0) begin
      mem_ready = 1'b0;
      stall--;
    end else begin
      mem_ready = mem_valid;
    end
  endtask

  // Settle combinational readies, record accepted requests, then advance a clock.
  task automatic step();
    resp_t r;
    cmd_t  c;
    #1;
    check_eq("ready_excl", 32'(d_req_ready && if_req_ready), 32'd0);
    if (d_req_valid && d_req_ready) begin
      r.data = d_req_write ? 32'h0 : bus_rdata;
      r.acc  = cyc;
      exp_d.push_back(r);
      c.addr = d_req_addr; c.wr = d_req_write; c.wdata = d_req_wdata;
      exp_cmd.push_back(c);
      grant_log.push_back(1'b0);
    end
    if (if_req_valid && if_req_ready) begin
      r.data = if_req_addr[1] ? {16'h0, bus_rdata[31:16]} : {16'h0, bus_rdata[15:0]};
      r.acc  = cyc;
      exp_i.push_back(r);
      c.addr = {if_req_addr[31:2], 2'b00}; c.wr = 1'b0; c.wdata = 32'h0;
      exp_cmd.push_back(c);
      grant_log.push_back(1'b1);
    end
    if (if_flush) exp_i.delete();
    tick();
  endtask

  task automatic issue_d(input logic [31:0] a, input logic wr, input logic [31:0] wd);
    int g;
    int n;
    g = grant_log.size();
    n = 0;
    d_req_valid = 1'b1; d_req_addr = a; d_req_write = wr; d_req_wdata = wd;
    while (grant_log.size() == g && n < 30) begin
      step();
      n++;
    end
    d_req_valid = 1'b0;
    check_eq("d_accept", 32'(grant_log.size() - g), 32'd1);
  endtask

  task automatic issue_i(input logic [31:0] a);
    int g;
    int n;
    g = grant_log.size();
    n = 0;
    if_req_valid = 1'b1; if_req_addr = a;
    while (grant_log.size() == g && n < 30) begin
      step();
      n++;
    end
    if_req_valid = 1'b0;
    check_eq("i_accept", 32'(grant_log.size() - g), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_d.size() + exp_i.size() + exp_cmd.size() > 0 || mem_valid) && n < 40) begin
      step();
      n++;
    end
    check_eq("drain", 32'(exp_d.size() + exp_i.size() + exp_cmd.size()), 32'd0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_d_resp_valid"}, 32'(d_resp_valid), 32'd0);
    check_eq({tag, "_d_resp_data"}, d_resp_data, 32'd0);
    check_eq({tag, "_if_resp_valid"}, 32'(if_resp_valid), 32'd0);
    check_eq({tag, "_if_resp_data"}, {16'h0, if_resp_data}, 32'd0);
    check_eq({tag, "_readies"}, {30'h0, d_req_ready, if_req_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int g0;
    int n;
    reset = 1'b1;
    if_req_valid = 1'b0; if_req_addr = 32'h0; if_flush = 1'b0;
    d_req_valid = 1'b0; d_req_addr = 32'h0; d_req_write = 1'b0; d_req_wdata = 32'h0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    step();
    step();
    check_all_zero("rst");
    reset = 1'b0;
    step();

    // Test 1: minimum-latency data read
    bus_rdata = 32'hDEAD_BEEF;
    d_req_valid = 1'b1; d_req_addr = 32'h2000_0010; d_req_write = 1'b0; d_req_wdata = 32'h0;
    #1;
    check_eq("t1_ready", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 1'b0;
    check_eq("t1_mem_valid", 32'(mem_valid), 32'd1);
    drain();
    check_eq("t1_latency", 32'(last_d_lat), 32'd3);

    // Test 2: fetch lanes
    bus_rdata = 32'h1234_ABCD;
    issue_i(32'h2000_0000);
    drain();
    issue_i(32'h2000_0002);
    drain();

    // Test 5: data write
    issue_d(32'h4000_0000, 1'b1, 32'h55AA_55AA);
    check_eq("t5_mem_write", 32'(mem_write), 32'd1);
    check_eq("t5_mem_wdata", mem_wdata, 32'h55AA_55AA);
    drain();

    // Test 4: stalled fetch, flushed during WAIT
    bus_rdata = 32'hCAFE_F00D;
    stall = 3;
    issue_i(32'h2000_0004);
    held = mem_addr;
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("t4_hold_valid", 32'(mem_valid), 32'd1);
      check_eq("t4_hold_addr", mem_addr, held);
    end
    bus_hold = 1'b1;
    step();
    check_eq("t4_wait_valid", 32'(mem_valid), 32'd0);
    if_flush = 1'b1;
    step();
    if_flush = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = bus_rdata;
    step();
    check_eq("t4_no_resp", 32'(if_resp_valid), 32'd0);
    bus_hold = 1'b0;
    step();
    issue_i(32'h2000_0006);
    drain();

    // Test 6: reset during WAIT, late response ignored
    bus_hold = 1'b1;
    bus_rdata = 32'h0BAD_0BAD;
    issue_d(32'h3000_0000, 1'b0, 32'h0);
    step();
    reset = 1'b1;
    step();
    check_all_zero("t6");
    exp_d.delete();
    exp_cmd.delete();
    reset = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = bus_rdata;
    step();
    step();
    check_eq("t6_no_resp", 32'(d_resp_valid), 32'd0);
    bus_hold = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h3000_0004; d_req_write = 1'b0;
    #1;
    check_eq("t6_idle_ready", 32'(d_req_ready), 32'd1);
    step();
    d_req_valid = 1'b0;
    drain();

    // Test 3: starvation limit grant order
    bus_rdata = 32'h8765_4321;
    g0 = grant_log.size();
    n = 0;
    d_req_valid = 1'b1; d_req_addr = 32'h1000_0000; d_req_write = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h2000_0002;
    while (grant_log.size() - g0 < 10 && n < 100) begin
      step();
      n++;
    end
    d_req_valid = 1'b0;
    if_req_valid = 1'b0;
    check_eq("t3_count", 32'(grant_log.size() - g0), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (g0 + k < grant_log.size())
        check_eq($sformatf("t3_grant%0d", k), 32'(grant_log[g0 + k]), 32'((k % 5) == 4));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/w0rm_mem_port_arbiter.md
Name: w0rm_mem_port_arbiter

Overview:
- Shares the core's single memory bus between the instruction-fetch stage (read-only, 16-bit instructions) and the memory/load-store stage (32-bit read/write).
- One outstanding bus transaction at a time.
- Fixed data-side priority, with an anti-starvation counter that guarantees fetch progress.
- Honours fetch flushes on branch by discarding a stale fetch response.

Parameters:
ADDR_WIDTH, 32, address width of all address ports
DATA_WIDTH, 32, memory bus and data-side width
INST_WIDTH, 16, fetch response width (DATA_WIDTH/2)
STARVE_LIMIT, 4, max consecutive data grants while a fetch request waits

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
if_req_valid  in  1  fetch request
if_req_addr  in  ADDR_WIDTH  fetch byte address (halfword aligned)
if_flush  in  1  branch flush; discard outstanding/queued fetch
if_req_ready  out  1  fetch request accepted this cycle
if_resp_valid  out  1  one-cycle pulse, fetch data valid
if_resp_data  out  INST_WIDTH  fetched instruction
d_req_valid  in  1  data request
d_req_addr  in  ADDR_WIDTH  data byte address
d_req_write  in  1  1=write, 0=read
d_req_wdata  in  DATA_WIDTH  write data
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  one-cycle pulse, read data / write ack
d_resp_data  out  DATA_WIDTH  read data (0 for writes)
mem_valid  out  1  bus command valid
mem_addr  out  ADDR_WIDTH  bus address
mem_write  out  1  bus write enable
mem_wdata  out  DATA_WIDTH  bus write data
mem_ready  in  1  bus accepts command this cycle
mem_resp_valid  in  1  bus response (one per command, reads and writes)
mem_resp_data  in  DATA_WIDTH  bus read data

Behaviour:

Reset values:
- All outputs 0; state IDLE; starve counter 0; owner/flush flags cleared.
- Reset mid-transaction aborts it. A later mem_resp_valid arriving in IDLE is ignored.

States:
- IDLE: the grant is decided combinationally. The granted requester sees its req_ready=1 in the same cycle, the command is registered into mem_*, and the FSM moves to ISSUE.
- ISSUE: mem_valid=1; mem_addr, mem_write and mem_wdata are held stable. On mem_ready=1, clear mem_valid and move to WAIT.
- WAIT: on mem_resp_valid=1, register the response to the owner and return to IDLE. The next grant is possible in the cycle after returning.
- req_ready is never asserted outside IDLE. mem_resp_valid in IDLE or ISSUE is ignored.

Grant rules (IDLE only):
- Only d valid: grant data. Only if valid: grant fetch.
- Both valid: grant data unless starve_cnt==STARVE_LIMIT, in which case grant fetch.
- starve_cnt increments (saturating) on each data grant while if_req_valid=1.
- starve_cnt clears on a fetch grant, or on any cycle with if_req_valid=0.
- if_flush=1 in IDLE blocks a fetch grant that cycle (the data side may still be granted).

Address and data:
- Fetch: mem_addr = if_req_addr with bits[1:0] forced to 0; lane bit = if_req_addr[1] is latched.
- Fetch response: if_resp_data = mem_resp_data[15:0] when lane=0, [31:16] when lane=1.
- Data: mem_addr = d_req_addr unchanged; mem_write = d_req_write.
- Fetch commands always drive mem_write=0 and mem_wdata=0.

Responses:
- Registered; the pulse appears in the cycle after mem_resp_valid.
- Minimum latency: accept at cycle N, mem_valid at N+1; with mem_ready=1 at N+1 and mem_resp_valid at N+2, the resp pulse is at N+3.
- d_resp_data = mem_resp_data for reads, 0 for writes.

Flush:
- if_flush=1 while fetch owns ISSUE/WAIT sets a drop flag. The bus transaction still completes, but if_resp_valid is suppressed; the flag clears on return to IDLE.
- if_flush while data owns the bus has no effect. if_flush coincident with mem_resp_valid for a fetch also drops that response.

Test Plan:
1. Single data read of 0x2000_0010, mem_ready=1 immediately, response 0xDEADBEEF one cycle later -> d_req_ready at N, mem_valid at N+1, d_resp_valid with data 0xDEADBEEF at N+3.
2. Fetches at 0x2000_0000 and 0x2000_0002 with bus data 0x1234_ABCD -> mem_addr 0x2000_0000 both times; if_resp_data 0xABCD then 0x1234.
3. d_req_valid and if_req_valid held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
4. Fetch issued, mem_ready low 3 cycles then high, if_flush pulsed during WAIT -> mem_* held stable while stalled; transaction completes; no if_resp_valid; next request is granted normally.
5. Data write 0x55AA_55AA to 0x4000_0000 -> mem_write=1, mem_wdata=0x55AA_55AA; d_resp_valid with d_resp_data=0.
6. Reset asserted during WAIT, then mem_resp_valid arrives -> all outputs 0, no resp pulse, state IDLE, starve_cnt 0.
